// File: rtl/shared_task_arbiter.sv
// shared_task_arbiter
//   Round-robin shares one three-phase compute unit (LOAD, ADD, MUL) among
//   NREQ requesters. The winner's argument is captured at grant. Only the
//   MUL-phase value is committed to result.
//
//   Optional build macro: SHARED_TASK_PHASE_OBS_EN exposes the ADD-phase
//   scratch value on phase_val/phase_valid in the first MUL cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req[NREQ]    per-requester request level
//   arg[NREQ*DW] packed arguments, requester i at arg[i*DW +: DW]
//   gnt[NREQ]    one-hot grant pulse (first LOAD cycle)
//   done[NREQ]   one-hot completion pulse to the owner (COMMIT cycle)
//   result[DW]   committed result, held until the next commit
//   result_valid high in the COMMIT cycle only
//   busy         high from the grant cycle through the commit cycle
//   phase_val[DW], phase_valid  (SHARED_TASK_PHASE_OBS_EN only)
module shared_task_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int STEP = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] arg,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      result,
   output logic               result_valid,
`ifdef SHARED_TASK_PHASE_OBS_EN
   output logic [DW-1:0]      phase_val,
   output logic               phase_valid,
`endif
   output logic               busy
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = (STEP > 1) ? $clog2(STEP) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(STEP - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ADD, MUL, COMMIT} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   ptr, owner, win, win_nxt;
   logic            found;
   logic [DW-1:0]   copy, scratch;
   logic [2*DW-1:0] prod;
   logic            phase_end;
   int              idx;

   assign phase_end = (cnt == '0);
   assign prod      = (2*DW)'(copy) * (2*DW)'(5);
   assign win_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

   // Rotating priority: scan from ptr upward, wrapping, first asserted wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      gnt          = '0;
      done         = '0;
      result_valid = 1'b0;
      busy         = (state != IDLE);
      case (state)
         IDLE: if (found) begin
            state_n = LOAD;
            cnt_n   = CNT_TOP;
         end
         LOAD, ADD, MUL: begin
            // First LOAD cycle is the only one with the counter at the top.
            if (state == LOAD && cnt == CNT_TOP) gnt[owner] = 1'b1;
            if (phase_end) begin
               cnt_n   = CNT_TOP;
               state_n = (state == LOAD) ? ADD : (state == ADD) ? MUL : COMMIT;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         COMMIT: begin
            done[owner]  = 1'b1;
            result_valid = 1'b1;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         copy    <= '0;
         owner   <= '0;
         ptr     <= '0;
         scratch <= '0;
         result  <= '0;
      end else begin
         if (state == IDLE && found) begin
            copy  <= arg[int'(win)*DW +: DW];
            owner <= win;
            ptr   <= win_nxt;
         end
         if (state == ADD && phase_end) scratch <= copy + DW'(3);
         // MUL overwrites scratch; result is loaded at the same edge so the
         // committed value is visible in the COMMIT cycle itself.
         if (state == MUL && phase_end) begin
            scratch <= prod[DW-1:0];
            result  <= prod[DW-1:0];
         end
      end
   end

`ifdef SHARED_TASK_PHASE_OBS_EN
   // scratch still holds copy+3 during the first MUL cycle.
   assign phase_valid = (state == MUL) && (cnt == CNT_TOP);
   assign phase_val   = phase_valid ? scratch : '0;
`endif

endmodule

// File: tb/tb_shared_task_arbiter.sv
module tb_shared_task_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] arg;
   logic [3:0]  gnt, done, result;
   logic        result_valid, busy;
`ifdef SHARED_TASK_PHASE_OBS_EN
   logic [3:0]  phase_val;
   logic        phase_valid;
`endif

   shared_task_arbiter #(.NREQ(4), .DW(4), .STEP(2)) dut (
      .clk(clk), .rst(rst), .req(req), .arg(arg),
      .gnt(gnt), .done(done), .result(result), .result_valid(result_valid),
`ifdef SHARED_TASK_PHASE_OBS_EN
      .phase_val(phase_val), .phase_valid(phase_valid),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int owner; logic [3:0] res;} sb_t;
   typedef struct {logic [3:0] req; logic [15:0] arg; int owner; logic [3:0] res;} vec_t;

   sb_t  q[$];
   vec_t tbl[8];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every commit must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && result_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_commit", 32'(done), 32'(0));
         end else begin
            sb_t e;
            e = q.pop_front();
            chk("commit_done", 32'(done), 32'(1) << e.owner);
            chk("commit_result", 32'(result), 32'(e.res));
         end
      end
   end

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (gnt != 4'b0) ok = 1'b1;
      end
      if (!ok) chk("gnt_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(q.size()), 32'(0));
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit ok;
      int lat, last, busy_bad, done_seen;
      sb_t e;

      tbl[0] = '{4'b0001, 16'h0002, 0, 4'd10};
      tbl[1] = '{4'b0010, 16'h0040, 1, 4'd4};
      tbl[2] = '{4'b1001, 16'h3001, 3, 4'd15};
      tbl[3] = '{4'b1001, 16'h3001, 0, 4'd5};
      tbl[4] = '{4'b0100, 16'h0700, 2, 4'd3};
      tbl[5] = '{4'b0111, 16'h0000, 0, 4'd0};
      tbl[6] = '{4'b1111, 16'hFFFF, 1, 4'd11};
      tbl[7] = '{4'b0001, 16'h0003, 0, 4'd15};

      arg = '0;
      do_reset();
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_result", 32'(result), 32'(0));
      chk("rst_rv", 32'(result_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));

      // Table: one isolated run per vector, ptr carried between them.
      for (int v = 0; v < 8; v++) begin
         req = tbl[v].req;
         arg = tbl[v].arg;
         e.owner = tbl[v].owner; e.res = tbl[v].res;
         q.push_back(e);
         wait_gnt(ok);
         chk("tbl_gnt", 32'(gnt), 32'(1) << tbl[v].owner);
         chk("tbl_busy_gnt", 32'(busy), 32'(1));
         req = '0;
         lat = 0; busy_bad = 0;
         while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!busy) busy_bad++;
            if (result_valid) break;
         end
         chk("tbl_latency", 32'(lat), 32'(6));
         chk("tbl_busy_run", 32'(busy_bad), 32'(0));
         @(negedge clk);
         chk("tbl_rv_low", 32'(result_valid), 32'(0));
         chk("tbl_result_held", 32'(result), 32'(tbl[v].res));
         chk("tbl_idle_busy", 32'(busy), 32'(0));
      end
      wait_drain();

      // Argument changed after capture has no effect.
      req = 4'b0010; arg = 16'h0040;
      e.owner = 1; e.res = 4'd4; q.push_back(e);
      wait_gnt(ok);
      chk("cap_gnt", 32'(gnt), 32'b0010);
      arg = 16'h0090; req = '0;
      @(negedge clk); arg = 16'h0090;
      wait_drain();

      // All requesting: 0,1,2,3 every 8 cycles, then 0,2,0 with only 0 and 2.
      do_reset();
      arg = 16'h1111;
      for (int k = 0; k < 7; k++) begin
         e.owner = (k < 4) ? k : ((k == 5) ? 2 : 0);
         e.res = 4'd5;
         q.push_back(e);
      end
      req = 4'b1111;
      last = 0;
      for (int k = 0; k < 7; k++) begin
         int exp_o;
         exp_o = (k < 4) ? k : ((k == 5) ? 2 : 0);
         wait_gnt(ok);
         chk("rr_gnt", 32'(gnt), 32'(1) << exp_o);
         if (k > 0) chk("rr_gap", 32'(cyc - last), 32'(8));
         last = cyc;
         if (k == 3) req = 4'b0101;
      end
      req = '0;
      wait_drain();

      // Reset during MUL abandons the run.
      do_reset();
      req = 4'b1000; arg = 16'h6000;
      wait_gnt(ok);
      chk("abort_gnt", 32'(gnt), 32'b1000);
      req = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_result", 32'(result), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      done_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done != 4'b0 || result_valid) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'(0));
      req = 4'b1010; arg = 16'h6030;
      e.owner = 1; e.res = 4'd15; q.push_back(e);
      wait_gnt(ok);
      chk("post_rst_gnt", 32'(gnt), 32'b0010);

      // req[2] raised while busy and dropped before arbitration: never granted.
      req = 4'b1100;
      for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
      req = 4'b1000;
      e.owner = 3; e.res = 4'd14; q.push_back(e);
      wait_gnt(ok);
      chk("drop_gnt", 32'(gnt), 32'b1000);
      req = '0;
      wait_drain();

`ifdef SHARED_TASK_PHASE_OBS_EN
      req = 4'b0001; arg = 16'h0005;
      e.owner = 0; e.res = 4'd9; q.push_back(e);
      wait_gnt(ok);
      chk("obs_gnt", 32'(gnt), 32'b0001);
      req = '0;
      repeat (3) @(negedge clk);
      chk("obs_pv_early", 32'(phase_valid), 32'(0));
      @(negedge clk);
      chk("obs_pv", 32'(phase_valid), 32'(1));
      chk("obs_val", 32'(phase_val), 32'(8));
      @(negedge clk);
      chk("obs_pv_late", 32'(phase_valid), 32'(0));
      wait_drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/shared_task_arbiter.md
Name: shared_task_arbiter

Overview:
- Shares one multi-phase compute unit between NREQ requesters. The unit runs a fixed three-phase sequence: LOAD, ADD, MUL.
- Argument is captured by value at grant. Changes to the requester's argument after capture have no effect on the run.
- Only the final phase value is committed to the shared result. Intermediate values never appear on result.
- Sits between requester agents and the compute resource. It sequences the phases and round-robin arbitrates access.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 4, argument/result width in bits
- STEP, 2, cycles each phase lasts (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level
- arg  input  NREQ*DW  packed arguments; requester i uses arg[i*DW +: DW]
- gnt  output  NREQ  one-hot grant pulse, 1 cycle
- done  output  NREQ  one-hot completion pulse, 1 cycle, to the owner
- result  output  DW  committed result, held until the next commit
- result_valid  output  1  high in the commit cycle only
- busy  output  1  high from the grant cycle through the commit cycle

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ptr=0, gnt=0, done=0, result=0, result_valid=0, busy=0. The local copy, scratch register and phase counter clear. An in-flight run is abandoned with no done.
- FSM states: IDLE -> LOAD -> ADD -> MUL -> COMMIT -> IDLE.
- IDLE, req!=0:
  - Round-robin pick: first asserted req starting at index ptr, wrapping.
  - At the clock edge: copy <= arg[winner], owner <= winner, ptr <= (winner+1) mod NREQ, state <= LOAD.
  - gnt[owner] is high in the first LOAD cycle (cycle c).
- IDLE, req==0: stay; all outputs other than result are 0.
- LOAD: lasts STEP cycles (c .. c+STEP-1). copy is untouched. Phase counter counts STEP-1 down to 0, then moves to the next phase.
- ADD: lasts STEP cycles. At its last edge, scratch <= (copy+3) mod 2^DW.
- MUL: lasts STEP cycles. At its last edge, scratch <= (copy*5) mod 2^DW. This overwrites the ADD value.
- COMMIT (cycle c+3*STEP):
  - result <= scratch, visible in this cycle (registered on entry).
  - result_valid=1 and done[owner]=1 for exactly one cycle.
  - Next state IDLE.
  - Earliest next gnt is at c+3*STEP+2. IDLE always takes one arbitration cycle.
- Latency: gnt to done = 3*STEP cycles (6 at default).
- Request rules:
  - req must be held until gnt. If dropped earlier, the request is forgotten.
  - req is ignored while busy.
  - A req still high after done is a new request.
- Simultaneous events:
  - A req rising in the COMMIT cycle is sampled in the following IDLE cycle.
  - Several reqs in IDLE: exactly one is granted, per ptr.
- Width rules:
  - All arithmetic is unsigned, truncated to DW, with no saturation.
  - The multiply product is formed at 2*DW bits and the low DW bits are kept.
- One owner at a time. gnt, done and result_valid are never high for more than one requester or cycle per run.

Optional Feature:
- Macro: SHARED_TASK_PHASE_OBS_EN
- Defined:
  - Adds output ports phase_val[DW] and phase_valid[1].
  - phase_valid pulses one cycle in the first MUL cycle, with phase_val = the ADD-phase scratch (copy+3).
  - Both are 0 at reset and otherwise.
  - result behaviour is unchanged.
- Undefined: these ports and their logic do not exist. Core behaviour is identical.

Test Plan:
- Reset, then req[0]=1 with arg0=2 -> gnt[0] at cycle c; done[0], result_valid and result=10 at c+6; busy high c..c+6.
- req[1] with arg1=4; arg1 changed to 9 at c+1 -> result=4 (20 mod 16), not 13.
- req=4'b1111, all held -> grants in order 0,1,2,3, each 8 cycles apart; then keep only req[0] and req[2] -> alternating 0,2,0.
- rst pulsed during MUL of a run for requester 3 -> no done; result=0; ptr=0; next req=4'b1010 grants 1 first.
- req[2] dropped one cycle before it would win -> no gnt[2]; other requesters proceed normally.
- SHARED_TASK_PHASE_OBS_EN defined, arg=5 -> phase_valid with phase_val=8 at c+4; result=9 (25 mod 16) at c+6.
